// File: rtl/simon32_64_core.sv
// Iterative Simon32/64 block encryptor: one round per clock, with the key
// schedule expanded alongside the datapath in a four-word shift register.
module simon32_64_core #(
  parameter int WIDTH  = 16,
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] key,
  input  logic [31:0] plaintext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ciphertext,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // z0 is read from the left: round r uses bit (61 - r)
  localparam logic [61:0] Z0_C =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [4:0] LAST_ROUND_C = 5'(ROUNDS - 1);

  function automatic logic [15:0] rol1(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  function automatic logic [15:0] rol2(input logic [15:0] v);
    return {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] rol8(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [15:0] ror1(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] v);
    return {v[2:0], v[15:3]};
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic [WIDTH-1:0]   k0_r;
  logic [WIDTH-1:0]   k1_r;
  logic [WIDTH-1:0]   k2_r;
  logic [WIDTH-1:0]   k3_r;
  logic [4:0]         round_r;
  logic               busy_r;
  logic               out_valid_r;
  logic [31:0]        ct_r;

  logic [WIDTH-1:0]   x_nx_s;
  logic [WIDTH-1:0]   tmp_s;
  logic [WIDTH-1:0]   knew_s;
  logic               z_bit_s;
  logic               last_s;

  // Round function and key expansion for the current round
  always_comb begin
    z_bit_s = Z0_C[6'd61 - {1'b0, round_r}];
    x_nx_s  = y_r ^ ((rol1(x_r) & rol8(x_r)) ^ rol2(x_r)) ^ k0_r;
    tmp_s   = ror3(k3_r) ^ k1_r;
    tmp_s   = tmp_s ^ ror1(tmp_s);
    knew_s  = 16'hFFFC ^ {15'd0, z_bit_s} ^ k0_r ^ tmp_s;
    last_s  = (round_r == LAST_ROUND_C);
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, key shift register, round counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= 16'd0;
      y_r         <= 16'd0;
      k0_r        <= 16'd0;
      k1_r        <= 16'd0;
      k2_r        <= 16'd0;
      k3_r        <= 16'd0;
      round_r     <= 5'd0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      ct_r        <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r     <= plaintext[31:16];
            y_r     <= plaintext[15:0];
            k0_r    <= key[15:0];
            k1_r    <= key[31:16];
            k2_r    <= key[47:32];
            k3_r    <= key[63:48];
            round_r <= 5'd0;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          x_r     <= x_nx_s;
          y_r     <= x_r;
          k0_r    <= k1_r;
          k1_r    <= k2_r;
          k2_r    <= k3_r;
          k3_r    <= knew_s;
          round_r <= round_r + 5'd1;
          if (last_s) begin
            ct_r        <= {x_nx_s, x_r};
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign busy       = busy_r;
  assign out_valid  = out_valid_r;
  assign ciphertext = ct_r;

endmodule
